fp_regfile_scoreboard: RTL and testbench

//  Parametrised FP register file with three read ports (rs1/rs2/rs3 for fused multiply-add) and two write ports.

---
 rtl/fp_rf_pkg.sv | 18 +
 rtl/fp_scoreboard.sv | 68 ++++++
 rtl/fp_regfile_scoreboard.sv | 98 +++++++++
 tb/tb_fp_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rf_pkg.sv
// Shared defaults and debug encodings for the FP register file and its busy scoreboard.
package fp_rf_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  function automatic int num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One bit per protocol violation, so a debugger can see which rule tripped.
  typedef struct packed {
    logic collision;  // wr0 and wr1 hit the same register
    logic waw;        // issue to a register that is still busy
    logic stray_wr1;  // long-latency writeback to a register nobody issued
  } err_cause_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register busy bits, pending-op counter and sticky protocol-error flag.
module fp_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = num_regs(ADDR_WIDTH)
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  iss_en,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy,
  output logic [ADDR_WIDTH:0]   pending,
  output logic                  error
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_WIDTH:0] pending_q, pending_d;
  logic                error_q;
  err_cause_t          cause;
  logic                clr_same, inc, dec;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cause           = '0;
    clr_same        = wr1_en && (wr1_addr == iss_addr);
    cause.collision = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    cause.waw       = iss_en && busy_q[iss_addr] && !clr_same;
    cause.stray_wr1 = wr1_en && !busy_q[wr1_addr] && !flush;

    // A same-cycle issue to the clearing address hands ownership to the new op.
    inc = iss_en && !busy_q[iss_addr];
    dec = wr1_en && busy_q[wr1_addr] && !(iss_en && clr_same);

    busy_d = busy_q;
    if (wr1_en) busy_d[wr1_addr] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;

    pending_d = pending_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    if (flush) begin
      busy_d    = '0;
      pending_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      busy_q    <= '0;
      pending_q <= '0;
      error_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      error_q   <= error_q || (|cause);
    end
  end

  assign busy    = busy_q;
  assign pending = pending_q;
  assign error   = error_q;

endmodule

// File: rtl/fp_regfile_scoreboard.sv
// FP register file: 3 read ports, 2 write ports, optional bypass, plus issue-stage busy scoreboard.
module fp_regfile_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic [ADDR_WIDTH-1:0] in_addr_A,
  input  logic [ADDR_WIDTH-1:0] in_addr_B,
  input  logic [ADDR_WIDTH-1:0] in_addr_C,
  output logic [DATA_WIDTH-1:0] out_data_A,
  output logic [DATA_WIDTH-1:0] out_data_B,
  output logic [DATA_WIDTH-1:0] out_data_C,
  output logic                  out_busy_A,
  output logic                  out_busy_B,
  output logic                  out_busy_C,
  input  logic                  in_wr0_En,
  input  logic [ADDR_WIDTH-1:0] in_wr0_Addr,
  input  logic [DATA_WIDTH-1:0] in_wr0_Data,
  input  logic                  in_wr1_En,
  input  logic [ADDR_WIDTH-1:0] in_wr1_Addr,
  input  logic [DATA_WIDTH-1:0] in_wr1_Data,
  input  logic                  in_issue_En,
  input  logic [ADDR_WIDTH-1:0] in_issue_Addr,
  input  logic                  in_flush,
  output logic [ADDR_WIDTH:0]   out_pending,
  output logic                  out_error
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
  } rd_t;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  wr0_v, wr1_v, iss_v;

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Traffic to a hardwired zero register is invisible to storage and scoreboard alike.
  assign wr0_v = in_wr0_En   && !is_zero_reg(in_wr0_Addr);
  assign wr1_v = in_wr1_En   && !is_zero_reg(in_wr1_Addr);
  assign iss_v = in_issue_En && !is_zero_reg(in_issue_Addr);

  // NOTE: the array is reset because architectural state must read 0 after reset.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (wr1_v) regs_q[in_wr1_Addr] <= in_wr1_Data;
      if (wr0_v) regs_q[in_wr0_Addr] <= in_wr0_Data;
    end
  end

  fp_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_sb (
    .in_Clk   (in_Clk),
    .in_Rst_N (in_Rst_N),
    .iss_en   (iss_v),
    .iss_addr (in_issue_Addr),
    .wr0_en   (wr0_v),
    .wr0_addr (in_wr0_Addr),
    .wr1_en   (wr1_v),
    .wr1_addr (in_wr1_Addr),
    .flush    (in_flush),
    .busy     (busy),
    .pending  (out_pending),
    .error    (out_error)
  );

  function automatic rd_t read_port(input logic [ADDR_WIDTH-1:0] a);
    rd_t r;
    r.data = regs_q[a];
    r.busy = busy[a];
    if (BYPASS != 0) begin
      if (wr1_v && in_wr1_Addr == a) begin
        r.data = in_wr1_Data;
        if (!(iss_v && in_issue_Addr == a)) r.busy = 1'b0;
      end
      if (wr0_v && in_wr0_Addr == a) r.data = in_wr0_Data;
    end
    if (is_zero_reg(a)) r.data = '0;
    return r;
  endfunction

  assign {out_data_A, out_busy_A} = read_port(in_addr_A);
  assign {out_data_B, out_busy_B} = read_port(in_addr_B);
  assign {out_data_C, out_busy_C} = read_port(in_addr_C);

endmodule

// File: tb/tb_fp_regfile_scoreboard.sv
// Directed bench: bypass, no-bypass and zero-register variants driven by one stimulus stream.
module tb_fp_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic          wr0_en, wr1_en, iss_en, flush;
  logic [AW-1:0] wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0] wr0_data, wr1_data;

  logic [DW-1:0] b_da, b_db, b_dc, n_da, n_db, n_dc, z_da, z_db, z_dc;
  logic          b_ba, b_bb, b_bc, n_ba, n_bb, n_bc, z_ba, z_bb, z_bc;
  logic [AW:0]   b_pend, n_pend, z_pend;
  logic          b_err, n_err, z_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1), .ZERO_REG(0)) u_byp (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_addr_A(addr_a), .in_addr_B(addr_b), .in_addr_C(addr_c),
    .out_data_A(b_da), .out_data_B(b_db), .out_data_C(b_dc),
    .out_busy_A(b_ba), .out_busy_B(b_bb), .out_busy_C(b_bc),
    .in_wr0_En(wr0_en), .in_wr0_Addr(wr0_addr), .in_wr0_Data(wr0_data),
    .in_wr1_En(wr1_en), .in_wr1_Addr(wr1_addr), .in_wr1_Data(wr1_data),
    .in_issue_En(iss_en), .in_issue_Addr(iss_addr), .in_flush(flush),
    .out_pending(b_pend), .out_error(b_err)
  );

  fp_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0), .ZERO_REG(0)) u_nob (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_addr_A(addr_a), .in_addr_B(addr_b), .in_addr_C(addr_c),
    .out_data_A(n_da), .out_data_B(n_db), .out_data_C(n_dc),
    .out_busy_A(n_ba), .out_busy_B(n_bb), .out_busy_C(n_bc),
    .in_wr0_En(wr0_en), .in_wr0_Addr(wr0_addr), .in_wr0_Data(wr0_data),
    .in_wr1_En(wr1_en), .in_wr1_Addr(wr1_addr), .in_wr1_Data(wr1_data),
    .in_issue_En(iss_en), .in_issue_Addr(iss_addr), .in_flush(flush),
    .out_pending(n_pend), .out_error(n_err)
  );

  fp_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1), .ZERO_REG(1)) u_zr (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_addr_A(addr_a), .in_addr_B(addr_b), .in_addr_C(addr_c),
    .out_data_A(z_da), .out_data_B(z_db), .out_data_C(z_dc),
    .out_busy_A(z_ba), .out_busy_B(z_bb), .out_busy_C(z_bc),
    .in_wr0_En(wr0_en), .in_wr0_Addr(wr0_addr), .in_wr0_Data(wr0_data),
    .in_wr1_En(wr1_en), .in_wr1_Addr(wr1_addr), .in_wr1_Data(wr1_data),
    .in_issue_En(iss_en), .in_issue_Addr(iss_addr), .in_flush(flush),
    .out_pending(z_pend), .out_error(z_err)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  // Advance one edge; inputs may be changed right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
  endtask

  initial begin
    idle();
    addr_a = '0; addr_b = '0; addr_c = '0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
    #22;
    rst_n = 1'b1;
    tick();

    check("rst_pending", 32'(b_pend), 32'd0);
    check("rst_error", 32'(b_err), 32'd0);
    check("rst_data_a", b_da, 32'd0);

    // Reset mid-run.
    write0(5'd5, 32'h3F800000); addr_a = 5'd5;
    #1;
    check("t1_byp_fwd", b_da, 32'h3F800000);
    check("t1_nob_old", n_da, 32'd0);
    tick();
    idle(); issue(5'd7);
    tick();
    idle(); addr_b = 5'd7;
    #1;
    check("t1_nob_data", n_da, 32'h3F800000);
    check("t1_busy_b", 32'(b_bb), 32'd1);
    check("t1_pending", 32'(b_pend), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_data", b_da, 32'd0);
    check("t1_rst_data_nob", n_da, 32'd0);
    check("t1_rst_busy", 32'(b_bb), 32'd0);
    check("t1_rst_pending", 32'(b_pend), 32'd0);
    check("t1_rst_error", 32'(b_err), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Same-cycle bypass vs next-cycle visibility.
    write0(5'd3, 32'h40490FDB); addr_a = 5'd3;
    #1;
    check("t2_byp_fwd", b_da, 32'h40490FDB);
    check("t2_nob_old", n_da, 32'd0);
    tick();
    idle();
    #1;
    check("t2_nob_new", n_da, 32'h40490FDB);

    // Issue f9, long-latency writeback four cycles later.
    issue(5'd9); addr_a = 5'd9;
    #1;
    check("t3_busy_issue_cycle", 32'(b_ba), 32'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_busy_wait", 32'(n_ba), 32'd1);
      check("t3_pending_wait", 32'(b_pend), 32'd1);
      tick();
    end
    write1(5'd9, 32'hC0000000);
    #1;
    check("t3_nob_busy_wb", 32'(n_ba), 32'd1);
    check("t3_nob_data_wb", n_da, 32'd0);
    check("t3_byp_busy_wb", 32'(b_ba), 32'd0);
    check("t3_byp_data_wb", b_da, 32'hC0000000);
    tick();
    idle();
    #1;
    check("t3_busy_after", 32'(n_ba), 32'd0);
    check("t3_pending_after", 32'(b_pend), 32'd0);
    check("t3_nob_data_after", n_da, 32'hC0000000);
    check("t3_error", 32'(b_err), 32'd0);

    // Issue + wr1 same register keeps it busy; then a WAW issue sets the error.
    issue(5'd4);
    tick();
    idle(); issue(5'd4); write1(5'd4, 32'h11111111); addr_a = 5'd4;
    #1;
    check("t4_byp_busy_reissue", 32'(b_ba), 32'd1);
    tick();
    idle();
    #1;
    check("t4_busy", 32'(n_ba), 32'd1);
    check("t4_pending", 32'(b_pend), 32'd1);
    check("t4_error_clean", 32'(b_err), 32'd0);
    check("t4_data", n_da, 32'h11111111);
    issue(5'd2);
    tick();
    idle(); issue(5'd2);
    tick();
    idle();
    #1;
    check("t4_waw_error", 32'(b_err), 32'd1);
    check("t4_pending_waw", 32'(b_pend), 32'd2);
    tick();
    tick();
    check("t4_error_sticky", 32'(n_err), 32'd1);

    // Flush overrides issue; wr0/wr1 collision stores wr0 data.
    pulse_reset();
    issue(5'd1); tick();
    issue(5'd2); tick();
    issue(5'd3); tick();
    idle();
    #1;
    check("t5_pending3", 32'(b_pend), 32'd3);
    check("t5_error0", 32'(b_err), 32'd0);
    flush = 1'b1; issue(5'd6);
    tick();
    idle(); addr_a = 5'd6; addr_b = 5'd1;
    #1;
    check("t5_flush_pending", 32'(b_pend), 32'd0);
    check("t5_flush_busy_a", 32'(b_ba), 32'd0);
    check("t5_flush_busy_b", 32'(b_bb), 32'd0);
    check("t5_flush_error", 32'(b_err), 32'd0);
    flush = 1'b1;
    write0(5'd8, 32'hAAAA5555); write1(5'd8, 32'h5555AAAA); addr_c = 5'd8;
    #1;
    check("t5_byp_wr0_prio", b_dc, 32'hAAAA5555);
    tick();
    idle();
    #1;
    check("t5_stored_wr0", n_dc, 32'hAAAA5555);
    check("t5_collision_err", 32'(b_err), 32'd1);
    check("t5_pending_end", 32'(b_pend), 32'd0);

    // Hardwired zero register.
    pulse_reset();
    write0(5'd0, 32'hFFFFFFFF); issue(5'd0); addr_a = 5'd0;
    #1;
    check("t6_zr_fwd", z_da, 32'd0);
    check("t6_byp_fwd", b_da, 32'hFFFFFFFF);
    tick();
    idle();
    #1;
    check("t6_zr_data", z_da, 32'd0);
    check("t6_zr_busy", 32'(z_ba), 32'd0);
    check("t6_zr_pending", 32'(z_pend), 32'd0);
    check("t6_zr_error", 32'(z_err), 32'd0);
    check("t6_byp_busy", 32'(b_ba), 32'd1);
    check("t6_byp_pending", 32'(b_pend), 32'd1);

    // Writeback to a register nobody issued.
    pulse_reset();
    write1(5'd10, 32'h12345678);
    tick();
    idle();
    #1;
    check("t7_stray_wr1_err", 32'(b_err), 32'd1);
    check("t7_stray_pending", 32'(b_pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
